// File: rtl/commit_dpi_packer_pkg.sv
// rtl/commit_dpi_packer_pkg.sv - shared types, word counts and header layout for the commit DPI packer
package commit_dpi_packer_pkg;
   localparam int DPI_W  = 32;
   localparam int XREG_W = 64;
   localparam int FREG_W = 64;

   typedef logic [DPI_W-1:0]  dpi_word_t;
   typedef logic [XREG_W-1:0] reg_t;
   typedef logic [FREG_W-1:0] freg_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   localparam int PC_WORDS   = ceil_div(XREG_W, DPI_W);
   localparam int XD_WORDS   = ceil_div(XREG_W, DPI_W);
   localparam int FD_WORDS   = ceil_div(FREG_W, DPI_W);
   localparam int DATA_WORDS = (XD_WORDS > FD_WORDS) ? XD_WORDS : FD_WORDS;
   localparam int MAX_WORDS  = (PC_WORDS > DATA_WORDS) ? PC_WORDS : DATA_WORDS;
   localparam int CNT_W      = $clog2(MAX_WORDS) + 1;
   localparam int PC_VEC_W   = PC_WORDS * DPI_W;
   localparam int DATA_VEC_W = DATA_WORDS * DPI_W;

   localparam int HDR_RD_LSB  = 0;
   localparam int HDR_RD_W    = 5;
   localparam int HDR_WE_BIT  = 5;
   localparam int HDR_FP_BIT  = 6;
   localparam int HDR_SEQ_LSB = 8;

   typedef struct packed {
      reg_t        pc;
      logic [4:0]  rd;
      logic        we;
      logic        fp;
      reg_t        xdata;
      freg_t       fdata;
   } commit_rec_t;
endpackage

// File: rtl/commit_rec_fifo.sv
// rtl/commit_rec_fifo.sv - synchronous FIFO of commit records, head visible combinationally
module commit_rec_fifo
   import commit_dpi_packer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  commit_rec_t wdata,
   output commit_rec_t rdata,
   output logic        full,
   output logic        empty
);
   localparam int AW = $clog2(DEPTH);

   commit_rec_t      mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;

   assign rdata = mem[rptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/commit_dpi_packer.sv
// rtl/commit_dpi_packer.sv - buffers commit records and serializes each into header, PC and data words
module commit_dpi_packer
   import commit_dpi_packer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int SEQ_W      = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rec_valid_i,
   output logic              rec_ready_o,
   input  logic [XREG_W-1:0] rec_pc_i,
   input  logic [4:0]        rec_rd_i,
   input  logic              rec_we_i,
   input  logic              rec_fp_i,
   input  logic [XREG_W-1:0] rec_xdata_i,
   input  logic [FREG_W-1:0] rec_fdata_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DPI_W-1:0]  out_word_o,
   output logic              out_last_o
);
   if (DPI_W < HDR_SEQ_LSB + SEQ_W) begin : g_hdr_too_narrow
      $error("DPI_W too narrow for header with SEQ_W sequence bits");
   end

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_PC   = 2'd2;
   localparam logic [1:0] ST_DATA = 2'd3;

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      n_data;
   logic [PC_VEC_W-1:0]   pc_vec;
   logic [DATA_VEC_W-1:0] data_vec;
   dpi_word_t             hdr;
   dpi_word_t             hdr_next;
   logic                  we_q;
   logic [SEQ_W-1:0]      seq;

   commit_rec_t in_rec;
   commit_rec_t head;
   logic        push, pop, full, empty;
   logic        fire, last_pc, last_data, done;

   assign in_rec = '{pc: rec_pc_i, rd: rec_rd_i, we: rec_we_i, fp: rec_fp_i,
                     xdata: rec_xdata_i, fdata: rec_fdata_i};

   // No bypass when full: acceptance depends only on registered occupancy.
   assign rec_ready_o = !full;
   assign push        = rec_valid_i && !full;

   commit_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push),
      .pop   (pop),
      .wdata (in_rec),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign out_valid_o = (state != ST_IDLE);
   assign fire        = out_valid_o && out_ready_i;
   assign last_pc     = (cnt == CNT_W'(PC_WORDS - 1));
   assign last_data   = (cnt == n_data - 1'b1);
   assign done        = fire && ((state == ST_PC && last_pc && !we_q) ||
                                 (state == ST_DATA && last_data));
   // Popping on the final handshake lets the next header follow without a bubble.
   assign pop         = !empty && (state == ST_IDLE || done);

   always_comb begin
      hdr_next = '0;
      hdr_next[HDR_RD_LSB +: HDR_RD_W] = head.rd;
      hdr_next[HDR_WE_BIT]             = head.we;
      hdr_next[HDR_FP_BIT]             = head.fp;
      hdr_next[HDR_SEQ_LSB +: SEQ_W]   = seq;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         n_data   <= '0;
         pc_vec   <= '0;
         data_vec <= '0;
         hdr      <= '0;
         we_q     <= 1'b0;
         seq      <= '0;
      end else if (pop) begin
         hdr      <= hdr_next;
         pc_vec   <= PC_VEC_W'(head.pc);
         data_vec <= head.fp ? DATA_VEC_W'(head.fdata) : DATA_VEC_W'(head.xdata);
         n_data   <= head.fp ? CNT_W'(FD_WORDS) : CNT_W'(XD_WORDS);
         we_q     <= head.we;
         seq      <= seq + 1'b1;
         cnt      <= '0;
         state    <= ST_HDR;
      end else if (done) begin
         state <= ST_IDLE;
      end else if (fire) begin
         case (state)
            ST_HDR: begin
               state <= ST_PC;
               cnt   <= '0;
            end
            ST_PC: begin
               if (last_pc) begin
                  state <= ST_DATA;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: cnt <= cnt + 1'b1;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      out_word_o = '0;
      out_last_o = 1'b0;
      case (state)
         ST_HDR:  out_word_o = hdr;
         ST_PC: begin
            out_word_o = pc_vec[int'(cnt) * DPI_W +: DPI_W];
            out_last_o = last_pc && !we_q;
         end
         ST_DATA: begin
            out_word_o = data_vec[int'(cnt) * DPI_W +: DPI_W];
            out_last_o = last_data;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_commit_dpi_packer.sv
// tb/tb_commit_dpi_packer.sv - directed self-checking bench for commit_dpi_packer
module tb_commit_dpi_packer;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        rec_valid_i = 1'b0;
   logic        rec_ready_o;
   logic [63:0] rec_pc_i = '0;
   logic [4:0]  rec_rd_i = '0;
   logic        rec_we_i = 1'b0;
   logic        rec_fp_i = 1'b0;
   logic [63:0] rec_xdata_i = '0;
   logic [63:0] rec_fdata_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [31:0] out_word_o;
   logic        out_last_o;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [32:0] got_q[$];
   int          got_cyc[$];
   logic [32:0] exp_q[$];

   commit_dpi_packer #(.FIFO_DEPTH(4), .SEQ_W(8)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rec_valid_i (rec_valid_i),
      .rec_ready_o (rec_ready_o),
      .rec_pc_i    (rec_pc_i),
      .rec_rd_i    (rec_rd_i),
      .rec_we_i    (rec_we_i),
      .rec_fp_i    (rec_fp_i),
      .rec_xdata_i (rec_xdata_i),
      .rec_fdata_i (rec_fdata_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_word_o  (out_word_o),
      .out_last_o  (out_last_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (!rst_i && out_valid_o && out_ready_i) begin
         got_q.push_back({out_last_o, out_word_o});
         got_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_rec(input logic [63:0] pc, input logic [4:0] rd, input logic we,
                          input logic fp, input logic [63:0] xd, input logic [63:0] fd);
      rec_pc_i = pc; rec_rd_i = rd; rec_we_i = we; rec_fp_i = fp;
      rec_xdata_i = xd; rec_fdata_i = fd;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [63:0] pc, input logic [4:0] rd, input logic we,
                       input logic fp, input logic [63:0] xd, input logic [63:0] fd);
      int n = 0;
      set_rec(pc, rd, we, fp, xd, fd);
      rec_valid_i = 1'b1;
      @(negedge clk_i);
      while (!rec_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 200) check("send_timeout", 64'(rec_ready_o), 64'd1);
      @(posedge clk_i); #1;
      rec_valid_i = 1'b0;
   endtask

   task automatic add_exp(input logic [63:0] pc, input logic [4:0] rd, input logic we,
                          input logic fp, input logic [63:0] xd, input logic [63:0] fd,
                          input logic [7:0] seq);
      logic [63:0] d;
      d = fp ? fd : xd;
      exp_q.push_back({1'b0, 16'h0, seq, 1'b0, fp, we, rd});
      exp_q.push_back({1'b0, pc[31:0]});
      exp_q.push_back({!we, pc[63:32]});
      if (we) begin
         exp_q.push_back({1'b0, d[31:0]});
         exp_q.push_back({1'b1, d[63:32]});
      end
   endtask

   task automatic wait_count(input int n);
      int k = 0;
      while (got_q.size() < n && k < 3000) begin
         @(negedge clk_i);
         k++;
      end
      if (k >= 3000) check("wait_words_timeout", 64'(got_q.size()), 64'(n));
      @(posedge clk_i); #1;
   endtask

   task automatic cmp_stream(input string pfx);
      int n;
      check({pfx, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_w%0d", pfx, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete(); got_cyc.delete(); exp_q.delete();
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      got_q.delete(); got_cyc.delete(); exp_q.delete();
   endtask

   function automatic logic [63:0] t4_pc(input int k);  return 64'h1000 + 64'(k) * 8; endfunction
   function automatic logic        t4_we(input int k);  return k != 1; endfunction
   function automatic logic        t4_fp(input int k);  return k == 2 || k == 4; endfunction
   function automatic logic [63:0] t4_xd(input int k);  return {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k)}; endfunction
   function automatic logic [63:0] t4_fd(input int k);  return {32'hF000_0000 + 32'(k), 32'h0000_000F + 32'(k)}; endfunction

   initial begin
      logic [31:0] hold_word;
      logic        hold_last;
      int          acc;
      int          stable_err;
      int          gaps;
      int          n;
      logic        took;

      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_word",  64'(out_word_o),  64'd0);
      check("rst_last",  64'(out_last_o),  64'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      check("rst_ready", 64'(rec_ready_o), 64'd1);

      // Test 1: integer write, header timing
      send(64'h0000000080000004, 5'd10, 1'b1, 1'b0, 64'h1122334455667788, 64'h0);
      @(negedge clk_i);
      check("t1_no_hdr_at_t", 64'(out_valid_o), 64'd0);
      @(posedge clk_i); #1;
      check("t1_hdr_valid", 64'(out_valid_o), 64'd1);
      check("t1_hdr_word",  64'(out_word_o),  64'h2A);
      wait_count(5);
      exp_q.push_back({1'b0, 32'h0000002A});
      exp_q.push_back({1'b0, 32'h80000004});
      exp_q.push_back({1'b0, 32'h00000000});
      exp_q.push_back({1'b0, 32'h55667788});
      exp_q.push_back({1'b1, 32'h11223344});
      cmp_stream("t1");

      // Test 2: no write, seq=1
      send(64'h10, 5'd10, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
      wait_count(3);
      exp_q.push_back({1'b0, 32'h0000010A});
      exp_q.push_back({1'b0, 32'h00000010});
      exp_q.push_back({1'b1, 32'h00000000});
      cmp_stream("t2");

      // Test 3: FP write selects fdata, seq=2
      send(64'h20, 5'd3, 1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D, 64'h3FF0000000000000);
      wait_count(5);
      exp_q.push_back({1'b0, 32'h00000263});
      exp_q.push_back({1'b0, 32'h00000020});
      exp_q.push_back({1'b0, 32'h00000000});
      exp_q.push_back({1'b0, 32'h00000000});
      exp_q.push_back({1'b1, 32'h3FF00000});
      cmp_stream("t3");

      // Test 4: stall mid-PC while five records are offered
      out_ready_i = 1'b0;
      send(64'hAAAABBBBCCCCDDDD, 5'd7, 1'b1, 1'b0, 64'h0102030405060708, 64'h0);
      add_exp(64'hAAAABBBBCCCCDDDD, 5'd7, 1'b1, 1'b0, 64'h0102030405060708, 64'h0, 8'd3);
      n = 0;
      while (!out_valid_o && n < 50) begin @(posedge clk_i); #1; n++; end
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      out_ready_i = 1'b0;
      @(negedge clk_i);
      hold_word = out_word_o;
      hold_last = out_last_o;
      check("t4_pc0_word", 64'(out_word_o), 64'hCCCCDDDD);
      @(posedge clk_i); #1;
      acc = 0;
      stable_err = 0;
      for (int c = 0; c < 5; c++) begin
         set_rec(t4_pc(acc), 5'(acc + 1), t4_we(acc), t4_fp(acc), t4_xd(acc), t4_fd(acc));
         rec_valid_i = 1'b1;
         @(negedge clk_i);
         if (out_word_o !== hold_word || out_last_o !== hold_last || !out_valid_o) stable_err++;
         took = rec_ready_o;
         @(posedge clk_i); #1;
         if (took) begin
            add_exp(t4_pc(acc), 5'(acc + 1), t4_we(acc), t4_fp(acc), t4_xd(acc), t4_fd(acc), 8'(4 + acc));
            acc++;
         end
      end
      check("t4_accepts", 64'(acc), 64'd4);
      check("t4_ready_low", 64'(rec_ready_o), 64'd0);
      check("t4_stable", 64'(stable_err), 64'd0);
      out_ready_i = 1'b1;
      n = 0;
      while (acc < 5 && n < 100) begin
         set_rec(t4_pc(acc), 5'(acc + 1), t4_we(acc), t4_fp(acc), t4_xd(acc), t4_fd(acc));
         rec_valid_i = 1'b1;
         @(negedge clk_i);
         took = rec_ready_o;
         @(posedge clk_i); #1;
         if (took) begin
            add_exp(t4_pc(acc), 5'(acc + 1), t4_we(acc), t4_fp(acc), t4_xd(acc), t4_fd(acc), 8'(4 + acc));
            acc++;
         end
         n++;
      end
      rec_valid_i = 1'b0;
      check("t4_fifth_accept", 64'(acc), 64'd5);
      wait_count(exp_q.size());
      cmp_stream("t4");

      // Test 5: 300 back-to-back records, seq wraps
      do_reset();
      for (int i = 0; i < 300; i++) begin
         send(64'(i) * 4, 5'(i % 32), 1'b0, 1'b0, 64'h0, 64'h0);
         add_exp(64'(i) * 4, 5'(i % 32), 1'b0, 1'b0, 64'h0, 64'h0, 8'(i % 256));
      end
      wait_count(900);
      gaps = 0;
      for (int i = 1; i < got_cyc.size(); i++)
         if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
      check("t5_no_bubble", 64'(gaps), 64'd0);
      if (got_q.size() == 900) begin
         check("t5_hdr256_seq", 64'(got_q[768][15:8]), 64'd0);
         check("t5_hdr299_seq", 64'(got_q[897][15:8]), 64'd43);
      end
      cmp_stream("t5");

      // Test 6: reset during DATA with two queued
      out_ready_i = 1'b0;
      send(64'h500, 5'd1, 1'b1, 1'b0, 64'h0000_1111_0000_2222, 64'h0);
      send(64'h600, 5'd2, 1'b0, 1'b0, 64'h0, 64'h0);
      send(64'h700, 5'd3, 1'b0, 1'b0, 64'h0, 64'h0);
      out_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 out_ready_i = 1'b0;
      check("t6_in_data", 64'(out_word_o), 64'h00002222);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check("t6_rst_valid", 64'(out_valid_o), 64'd0);
      check("t6_rst_word",  64'(out_word_o),  64'd0);
      check("t6_rst_last",  64'(out_last_o),  64'd0);
      check("t6_rst_ready", 64'(rec_ready_o), 64'd1);
      rst_i = 1'b0;
      out_ready_i = 1'b1;
      got_q.delete(); got_cyc.delete(); exp_q.delete();
      repeat (3) @(posedge clk_i);
      #1;
      check("t6_fifo_flushed", 64'(out_valid_o), 64'd0);
      send(64'h800, 5'd4, 1'b0, 1'b0, 64'h0, 64'h0);
      wait_count(3);
      exp_q.push_back({1'b0, 32'h00000004});
      exp_q.push_back({1'b0, 32'h00000800});
      exp_q.push_back({1'b1, 32'h00000000});
      cmp_stream("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
